// File: rtl/pipe_hazard_if.sv
//------------------------------------------------------------------------
// pipe_hazard_if - pipeline <-> hazard sequencer signal bundle. Rev 1.0
//------------------------------------------------------------------------
`default_nettype none

interface pipe_hazard_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       ex_redirect;
  logic       ex_halt;
  logic       mem_req;
  logic       dmem_ready;

  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       memwb_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       memwb_flush;
  logic       dmem_valid;
  logic       halted;

  // master: the hazard sequencer, which drives the pipeline controls
  modport master (
    input  id_rs1, id_rs2, ex_memread, ex_rd, ex_redirect, ex_halt,
           mem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush, dmem_valid, halted
  );

  modport slave (
    output id_rs1, id_rs2, ex_memread, ex_rd, ex_redirect, ex_halt,
           mem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush, dmem_valid, halted
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
//------------------------------------------------------------------------
// pipe_hazard_ctrl - 5-stage pipeline stall/flush/halt sequencer. Rev 1.0
//------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_hazard_if.master          hz,
  output logic                   mem_err_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_e;

  localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [1:0]             drain_cnt_q, drain_cnt_d;
  logic [7:0]             wait_cnt_q, wait_cnt_d;
  logic                   mem_err_q, mem_err_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   mem_stall;
  logic                   load_use;

  assign mem_stall = hz.mem_req && !hz.dmem_ready;
  assign load_use  = hz.ex_memread && (hz.ex_rd != 5'd0) &&
                     ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

  always_comb begin
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    hz.pc_en       = 1'b1;
    hz.ifid_en     = 1'b1;
    hz.idex_en     = 1'b1;
    hz.exmem_en    = 1'b1;
    hz.memwb_en    = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.memwb_flush = 1'b0;
    hz.dmem_valid  = 1'b0;
    hz.halted      = 1'b0;

    unique case (state_q)
      S_RUN: begin
        hz.dmem_valid = hz.mem_req;
        if (mem_stall) begin
          hz.pc_en       = 1'b0;
          hz.ifid_en     = 1'b0;
          hz.idex_en     = 1'b0;
          hz.exmem_en    = 1'b0;
          hz.memwb_flush = 1'b1;
          wait_cnt_d     = 8'd0;
          state_d        = S_MEM_WAIT;
        end else if (hz.ex_redirect) begin
          hz.ifid_flush = 1'b1;
          hz.idex_flush = 1'b1;
        end else if (hz.ex_halt) begin
          hz.pc_en      = 1'b0;
          hz.ifid_en    = 1'b0;
          hz.idex_flush = 1'b1;
          drain_cnt_d   = 2'd2;
          state_d       = S_DRAIN;
        end else if (load_use) begin
          hz.pc_en      = 1'b0;
          hz.ifid_en    = 1'b0;
          hz.idex_flush = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        hz.dmem_valid = 1'b1;
        // The completing cycle releases the pipe without looking at EX
        if (hz.dmem_ready) begin
          state_d = S_RUN;
        end else begin
          hz.pc_en       = 1'b0;
          hz.ifid_en     = 1'b0;
          hz.idex_en     = 1'b0;
          hz.exmem_en    = 1'b0;
          hz.memwb_flush = 1'b1;
          if (wait_cnt_q == C_WAIT_LAST) begin
            mem_err_d = 1'b1;
            state_d   = S_HALTED;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      S_DRAIN: begin
        hz.pc_en      = 1'b0;
        hz.ifid_en    = 1'b0;
        hz.ifid_flush = 1'b1;
        hz.idex_flush = 1'b1;
        hz.dmem_valid = hz.mem_req;
        if (mem_stall) begin
          hz.exmem_en    = 1'b0;
          hz.memwb_flush = 1'b1;
        end else if (drain_cnt_q == 2'd1) begin
          drain_cnt_d = 2'd0;
          state_d     = S_HALTED;
        end else begin
          drain_cnt_d = drain_cnt_q - 2'd1;
        end
      end

      default: begin
        hz.pc_en    = 1'b0;
        hz.ifid_en  = 1'b0;
        hz.idex_en  = 1'b0;
        hz.exmem_en = 1'b0;
        hz.memwb_en = 1'b0;
        hz.halted   = 1'b1;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((state_q != S_HALTED) && !hz.pc_en && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);

    // Held in reset, every stage is frozen and loaded with bubbles
    if (!rst_n) begin
      hz.pc_en       = 1'b0;
      hz.ifid_en     = 1'b0;
      hz.idex_en     = 1'b0;
      hz.exmem_en    = 1'b0;
      hz.memwb_en    = 1'b0;
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.memwb_flush = 1'b1;
      hz.dmem_valid  = 1'b0;
      hz.halted      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      drain_cnt_q <= 2'd0;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//------------------------------------------------------------------------
// tb_pipe_hazard_ctrl - directed + random bench against a rule model. Rev 1.0
//------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_ctrl;
  localparam int TO        = 4;
  localparam int SW        = 4;
  localparam int STALL_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_err;
  logic [SW-1:0] stall_cnt;

  pipe_hazard_if hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hz         (hz),
    .mem_err_o  (mem_err),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: pipeline situation described by simple counters
  bit m_parked, m_waiting, m_err;
  int m_waited, m_drain_left, m_stalls;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_ctl();
    logic pc, fi, ix, em, mw, ffi, fix, fmw, dv, h, stall_mem, lu;
    pc = 1'b1; fi = 1'b1; ix = 1'b1; em = 1'b1; mw = 1'b1;
    ffi = 1'b0; fix = 1'b0; fmw = 1'b0; dv = 1'b0; h = 1'b0;
    stall_mem = hz.mem_req && !hz.dmem_ready;
    lu = hz.ex_memread && (hz.ex_rd != 5'd0) &&
         ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
    if (!rst_n) begin
      {pc, fi, ix, em, mw} = 5'b0;
      {ffi, fix, fmw} = 3'b111;
    end else if (m_parked) begin
      {pc, fi, ix, em, mw} = 5'b0;
      h = 1'b1;
    end else if (m_waiting) begin
      dv = 1'b1;
      if (!hz.dmem_ready) begin
        {pc, fi, ix, em} = 4'b0;
        fmw = 1'b1;
      end
    end else if (m_drain_left > 0) begin
      pc = 1'b0; fi = 1'b0; ffi = 1'b1; fix = 1'b1; dv = hz.mem_req;
      if (stall_mem) begin
        em = 1'b0; fmw = 1'b1;
      end
    end else begin
      dv = hz.mem_req;
      if (stall_mem) begin
        {pc, fi, ix, em} = 4'b0;
        fmw = 1'b1;
      end else if (hz.ex_redirect) begin
        ffi = 1'b1; fix = 1'b1;
      end else if (hz.ex_halt || lu) begin
        pc = 1'b0; fi = 1'b0; fix = 1'b1;
      end
    end
    return {pc, fi, ix, em, mw, ffi, fix, fmw, dv, h};
  endfunction

  task automatic model_step();
    logic [9:0] c;
    c = exp_ctl();
    if (!rst_n) begin
      m_parked = 0; m_waiting = 0; m_err = 0;
      m_waited = 0; m_drain_left = 0; m_stalls = 0;
      return;
    end
    if (m_parked) return;
    if (!c[9] && m_stalls < STALL_MAX) m_stalls++;
    if (m_waiting) begin
      if (hz.dmem_ready) m_waiting = 0;
      else begin
        m_waited++;
        if (m_waited >= TO) begin
          m_waiting = 0; m_parked = 1; m_err = 1;
        end
      end
    end else if (m_drain_left > 0) begin
      if (!(hz.mem_req && !hz.dmem_ready)) begin
        m_drain_left--;
        if (m_drain_left == 0) m_parked = 1;
      end
    end else if (hz.mem_req && !hz.dmem_ready) begin
      m_waiting = 1; m_waited = 0;
    end else if (!hz.ex_redirect && hz.ex_halt) begin
      m_drain_left = 2;
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic mrd,
                        input logic [4:0] rd, input logic redir, input logic halt,
                        input logic req, input logic rdy);
    hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.ex_memread = mrd; hz.ex_rd = rd;
    hz.ex_redirect = redir; hz.ex_halt = halt; hz.mem_req = req; hz.dmem_ready = rdy;
  endtask

  // called at a falling edge with inputs already driven
  task automatic cycle();
    logic [9:0] obs;
    #1;
    obs = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
           hz.ifid_flush, hz.idex_flush, hz.memwb_flush, hz.dmem_valid, hz.halted};
    check("ctl", 32'(obs), 32'(exp_ctl()));
    check("mem_err", 32'(mem_err), rst_n ? 32'(m_err) : 32'd0);
    check("stall_cnt", 32'(stall_cnt), rst_n ? 32'(m_stalls) : 32'd0);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("rst_ctl", 32'({hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                          hz.ifid_flush, hz.idex_flush, hz.memwb_flush, hz.dmem_valid,
                          hz.halted}), 32'b0000011100);
    @(negedge clk);
    do_reset();

    // load-use, then x0 exemption, then redirect beating load-use
    set_in(5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    set_in(5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    set_in(5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    set_in(5'd3, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1); cycle();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    check("redir_cnt", 32'(stall_cnt), 32'd1);

    // 3-cycle memory wait, halt pending in EX meanwhile
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); cycle();
    end
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); cycle();
    check("mw_cnt", 32'(stall_cnt), 32'd3);
    // halt now acted on: 1 edge to drain + 2 drain cycles
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); cycle();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle();
    check("halted", 32'(hz.halted), 32'd1);
    for (int i = 0; i < 3; i++) cycle();
    check("halt_cnt", 32'(stall_cnt), 32'd6);

    // timeout
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < TO + 1; i++) cycle();
    check("to_err", 32'(mem_err), 32'd1);
    check("to_halt", 32'(hz.halted), 32'd1);
    cycle();
    do_reset();
    check("to_clr", 32'(mem_err), 32'd0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst_n = !((m_parked && ($urandom % 4 == 0)) || ($urandom % 150 == 0));
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom % 2),
             5'($urandom_range(0, 3)), 1'(($urandom % 100) < 15), 1'(($urandom % 100) < 4),
             1'(($urandom % 100) < 35), 1'(($urandom % 100) < 55));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
